// File: rtl/pc_ctrl_pkg.sv
// Shared definitions for the program-counter controller and the
// branch-target lookup table that sits next to it.
package pc_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } pc_state_t;

    localparam int LUT_SEL_W        = 3;
    localparam int DEFAULT_PC_W     = 10;
    localparam int DEFAULT_START_PC = 0;

endpackage

// File: rtl/pc_sequencer.sv
// Program-counter controller: start/run/done sequencing, +1 or LUT-relative
// PC advance, and a saturating retired-instruction counter.
module pc_sequencer
    import pc_ctrl_pkg::*;
#(
    parameter int PC_width  = DEFAULT_PC_W,
    parameter int CNT_width = 16,
    parameter int START_PC  = DEFAULT_START_PC
) (
    input  logic                 Clk,
    input  logic                 Reset,
    input  logic                 start,
    input  logic                 halt_req,
    input  logic                 stall,
    input  logic                 branch_en,
    input  logic                 branch_taken,
    input  logic [LUT_SEL_W-1:0] branch_sel,
    output logic [LUT_SEL_W-1:0] lut_addr,
    input  logic [PC_width-1:0]  lut_data,
    output logic [PC_width-1:0]  pc,
    output logic                 running,
    output logic                 done,
    output logic [CNT_width-1:0] instr_count
);

    localparam logic [PC_width-1:0] START_PC_V = PC_width'(START_PC);

    pc_state_t            state;
    pc_state_t            stateNext;
    logic [PC_width-1:0]  pcNext;
    logic [CNT_width-1:0] countNext;
    logic [CNT_width-1:0] countInc;

    assign lut_addr = branch_sel;
    assign running  = (state == RUN);
    assign done     = (state == DONE);

    // Counter stops at all-ones rather than wrapping
    assign countInc = (instr_count == {CNT_width{1'b1}}) ? instr_count
                                                         : instr_count + 1'b1;

    always_comb begin
        stateNext = state;
        pcNext    = pc;
        countNext = instr_count;
        case (state)
            IDLE, DONE: begin
                if (start) begin
                    stateNext = RUN;
                    pcNext    = START_PC_V;
                    countNext = '0;
                end
            end
            RUN: begin
                if (!stall) begin
                    countNext = countInc;
                    if (halt_req) begin
                        stateNext = DONE;
                    end else if (branch_en && branch_taken) begin
                        pcNext = pc + lut_data;
                    end else begin
                        pcNext = pc + 1'b1;
                    end
                end
            end
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state       <= IDLE;
            pc          <= '0;
            instr_count <= '0;
        end else begin
            state       <= stateNext;
            pc          <= pcNext;
            instr_count <= countNext;
        end
    end

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: directed scenarios plus random
// traffic, compared against an arithmetic reference model.
module tb_pc_sequencer;

    localparam int PCW    = 10;
    localparam int CNTW   = 4;
    localparam int PCMOD  = 1 << PCW;
    localparam int CNTMAX = (1 << CNTW) - 1;

    logic            Clk = 1'b0;
    logic            Reset;
    logic            start;
    logic            halt_req;
    logic            stall;
    logic            branch_en;
    logic            branch_taken;
    logic [2:0]      branch_sel;
    logic [2:0]      lut_addr;
    logic [PCW-1:0]  lut_data;
    logic [PCW-1:0]  pc;
    logic            running;
    logic            done;
    logic [CNTW-1:0] instr_count;

    int vectors     = 0;
    int miscompares = 0;

    // Reference model state
    int mPc;
    int mCnt;
    bit mRun;
    bit mDone;

    int offsets [8] = '{-4, 3, 7, 1, 1, 1, 1, 1};

    pc_sequencer #(
        .PC_width (PCW),
        .CNT_width(CNTW),
        .START_PC (0)
    ) dut (
        .Clk         (Clk),
        .Reset       (Reset),
        .start       (start),
        .halt_req    (halt_req),
        .stall       (stall),
        .branch_en   (branch_en),
        .branch_taken(branch_taken),
        .branch_sel  (branch_sel),
        .lut_addr    (lut_addr),
        .lut_data    (lut_data),
        .pc          (pc),
        .running     (running),
        .done        (done),
        .instr_count (instr_count)
    );

    always #5 Clk = ~Clk;

    // External branch-target table, standard contents
    always_comb begin
        lut_data = PCW'(offsets[lut_addr]);
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        vectors++;
        if (observed !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t",
                     tag, observed, expected, $time);
        end
    endtask

    task automatic applyStimulus(input bit r, input bit s, input bit h,
                                 input bit st, input bit be, input bit bt,
                                 input int sel);
        Reset        = r;
        start        = s;
        halt_req     = h;
        stall        = st;
        branch_en    = be;
        branch_taken = bt;
        branch_sel   = 3'(sel);
        #1;
        checkOutput("lut_addr", 32'(lut_addr), 32'(sel));
        if (r) begin
            mRun = 0; mDone = 0; mPc = 0; mCnt = 0;
        end else if (!mRun) begin
            if (s) begin
                mRun = 1; mDone = 0; mPc = 0; mCnt = 0;
            end
        end else if (!st) begin
            mCnt = (mCnt < CNTMAX) ? mCnt + 1 : CNTMAX;
            if (h) begin
                mRun = 0; mDone = 1;
            end else begin
                mPc = (mPc + ((be && bt) ? offsets[sel] : 1) + PCMOD) % PCMOD;
            end
        end
        @(posedge Clk);
        #1;
        checkOutput("pc", 32'(pc), 32'(mPc));
        checkOutput("instr_count", 32'(instr_count), 32'(mCnt));
        checkOutput("running", 32'(running), 32'(mRun));
        checkOutput("done", 32'(done), 32'(mDone));
    endtask

    task automatic freeCycles(input int n);
        for (int i = 0; i < n; i++) applyStimulus(0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        mPc = 0; mCnt = 0; mRun = 0; mDone = 0;
        @(negedge Clk);

        // Reset and start-up
        applyStimulus(1, 0, 0, 0, 0, 0, 0);
        applyStimulus(1, 0, 0, 0, 0, 0, 0);
        checkOutput("reset_pc", 32'(pc), 32'd0);
        applyStimulus(0, 1, 0, 0, 0, 0, 0);
        checkOutput("start_running", 32'(running), 32'd1);
        freeCycles(4);
        checkOutput("t1_pc", 32'(pc), 32'd4);
        checkOutput("t1_cnt", 32'(instr_count), 32'd4);

        // Branches from pc=8
        freeCycles(4);
        applyStimulus(0, 0, 0, 0, 1, 1, 0);
        checkOutput("t2_back", 32'(pc), 32'd4);
        applyStimulus(0, 0, 0, 0, 1, 1, 2);
        checkOutput("t2_fwd", 32'(pc), 32'd11);
        applyStimulus(0, 0, 0, 0, 1, 1, 5);
        applyStimulus(0, 0, 0, 0, 1, 0, 1);
        checkOutput("t2_not_taken", 32'(pc), 32'd13);

        // Halt, restart at 0, wrap both ways
        applyStimulus(0, 0, 1, 0, 0, 0, 0);
        applyStimulus(0, 1, 0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 1, 1, 0);
        checkOutput("t3_wrap_neg", 32'(pc), 32'h3FC);
        freeCycles(4);
        checkOutput("t3_wrap_pos", 32'(pc), 32'h000);

        // Stall dominates halt and branch
        freeCycles(5);
        for (int i = 0; i < 3; i++) applyStimulus(0, 0, 1, 1, 1, 1, 1);
        checkOutput("t4_stall_pc", 32'(pc), 32'd5);
        applyStimulus(0, 0, 1, 0, 0, 0, 0);
        checkOutput("t4_halt_done", 32'(done), 32'd1);

        // Free run to halt at pc=9, hold, restart
        applyStimulus(0, 1, 0, 0, 0, 0, 0);
        freeCycles(9);
        applyStimulus(0, 0, 1, 0, 0, 0, 0);
        checkOutput("t5_cnt", 32'(instr_count), 32'd10);
        for (int i = 0; i < 5; i++) applyStimulus(0, 0, 1, 0, 1, 1, 2);
        checkOutput("t5_hold_pc", 32'(pc), 32'd9);
        applyStimulus(0, 1, 0, 0, 0, 0, 0);

        // Reset mid-run, start ignored in RUN, counter saturation
        freeCycles(6);
        applyStimulus(1, 1, 0, 0, 1, 1, 2);
        checkOutput("t6_reset_run", 32'(running), 32'd0);
        applyStimulus(0, 1, 0, 0, 0, 0, 0);
        freeCycles(3);
        applyStimulus(0, 1, 0, 0, 0, 0, 0);
        checkOutput("t6_start_ignored", 32'(pc), 32'd4);
        freeCycles(20);
        checkOutput("sat_cnt", 32'(instr_count), 32'(CNTMAX));

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            applyStimulus($urandom_range(0, 49) == 0,
                          $urandom_range(0, 9) == 0,
                          $urandom_range(0, 19) == 0,
                          $urandom_range(0, 4) == 0,
                          $urandom_range(0, 1) == 1,
                          $urandom_range(0, 1) == 1,
                          int'($urandom_range(0, 7)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
